pipeline_exb_stage_bp: RTL and testbench

Parametrised branch-resolution stage for the 5-stage pipeline, sitting between the IDR and EXA stages. It resolves conditional branches, JAL and JALR in the same cycle, checks the front-end prediction, and issues a one-shot redirect plus a predictor-update strobe. Its registered IDR→EXB pipeline register carries a valid bit with flush/stall handling. Saturating branch and mispredict counters provide performance monitoring.

---
 rtl/pipeline_exb_stage_bp.sv | 161 ++++++++++++++++
 tb/tb_pipeline_exb_stage_bp.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exb_stage_bp.sv
// Branch-resolution stage between IDR and EXA: resolves branches/JAL/JALR,
// checks the front-end prediction, emits a one-shot redirect and a predictor
// update strobe, registers the IDR fields, and keeps saturating perf counters.
module pipeline_exb_stage_bp #(
    parameter int XLEN       = 64,
    parameter int CNT_W      = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             perf_clr,
    input  logic             valid_IDR,
    input  logic [XLEN-1:0]  pc_IDR,
    input  logic [XLEN-1:0]  reg_data1_IDR,
    input  logic [XLEN-1:0]  reg_data2_IDR,
    input  logic [XLEN-1:0]  imm_IDR,
    input  logic [4:0]       rd_IDR,
    input  logic             rf_wr_en_IDR,
    input  logic [1:0]       rf_wr_sel_IDR,
    input  logic [3:0]       alu_ctrl_IDR,
    input  logic             alu_a_sel_IDR,
    input  logic             alu_b_sel_IDR,
    input  logic [2:0]       dm_rd_ctrl_IDR,
    input  logic [2:0]       dm_wr_ctrl_IDR,
    input  logic             do_jump_IDR,
    input  logic             is_jalr_IDR,
    input  logic             is_branch_IDR,
    input  logic [2:0]       BrType_IDR,
    input  logic             pred_taken_IDR,
    input  logic [XLEN-1:0]  pred_target_IDR,
    output logic             redirect_EXB,
    output logic [XLEN-1:0]  redirect_target_EXB,
    output logic             bp_upd_valid,
    output logic [XLEN-1:0]  bp_upd_pc,
    output logic             bp_upd_taken,
    output logic [XLEN-1:0]  bp_upd_target,
    output logic             valid_EXB,
    output logic [XLEN-1:0]  pc_EXB,
    output logic [XLEN-1:0]  reg_data1_EXB,
    output logic [XLEN-1:0]  reg_data2_EXB,
    output logic [XLEN-1:0]  imm_EXB,
    output logic [4:0]       rd_EXB,
    output logic             rf_wr_en_EXB,
    output logic [1:0]       rf_wr_sel_EXB,
    output logic [3:0]       alu_ctrl_EXB,
    output logic             alu_a_sel_EXB,
    output logic             alu_b_sel_EXB,
    output logic [2:0]       dm_rd_ctrl_EXB,
    output logic [2:0]       dm_wr_ctrl_EXB,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic            fire;
    logic            ctl;
    logic            cond;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] next_pc;

    // Branch condition from the funct3 encoding; 010/011 are never taken.
    always_comb begin
        cond = 1'b0;
        case (BrType_IDR)
            3'b000:  cond = (reg_data1_IDR == reg_data2_IDR);
            3'b001:  cond = (reg_data1_IDR != reg_data2_IDR);
            3'b100:  cond = ($signed(reg_data1_IDR) <  $signed(reg_data2_IDR));
            3'b101:  cond = ($signed(reg_data1_IDR) >= $signed(reg_data2_IDR));
            3'b110:  cond = (reg_data1_IDR <  reg_data2_IDR);
            3'b111:  cond = (reg_data1_IDR >= reg_data2_IDR);
            default: cond = 1'b0;
        endcase
    end

    assign fire         = valid_IDR & ~stall & ~flush;
    assign ctl          = is_branch_IDR | do_jump_IDR | is_jalr_IDR;
    assign taken        = (is_branch_IDR & cond) | do_jump_IDR | is_jalr_IDR;
    assign jalr_sum     = reg_data1_IDR + imm_IDR;
    assign target       = is_jalr_IDR ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_IDR + imm_IDR);
    assign fall_through = pc_IDR + XLEN'(ILEN_BYTES);
    assign next_pc      = taken ? target : fall_through;
    // A non-control instruction predicted taken also lands here (taken=0).
    assign mispredict   = (taken != pred_taken_IDR) |
                          (taken & pred_taken_IDR & (pred_target_IDR != target));

    // Stall gates both strobes, so each instruction produces at most one pulse.
    assign redirect_EXB        = fire & mispredict;
    assign redirect_target_EXB = redirect_EXB ? next_pc : '0;
    assign bp_upd_valid        = fire & ctl;
    assign bp_upd_pc           = bp_upd_valid ? pc_IDR : '0;
    assign bp_upd_taken        = bp_upd_valid & taken;
    assign bp_upd_target       = bp_upd_valid ? target : '0;

    // EXB pipeline register: reset > flush > stall(hold) > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            valid_EXB      <= 1'b0;
            pc_EXB         <= '0;
            reg_data1_EXB  <= '0;
            reg_data2_EXB  <= '0;
            imm_EXB        <= '0;
            rd_EXB         <= '0;
            rf_wr_en_EXB   <= 1'b0;
            rf_wr_sel_EXB  <= '0;
            alu_ctrl_EXB   <= '0;
            alu_a_sel_EXB  <= 1'b0;
            alu_b_sel_EXB  <= 1'b0;
            dm_rd_ctrl_EXB <= '0;
            dm_wr_ctrl_EXB <= '0;
        end else if (!stall) begin
            valid_EXB      <= valid_IDR;
            pc_EXB         <= pc_IDR;
            reg_data1_EXB  <= reg_data1_IDR;
            reg_data2_EXB  <= reg_data2_IDR;
            imm_EXB        <= imm_IDR;
            rd_EXB         <= rd_IDR;
            rf_wr_en_EXB   <= rf_wr_en_IDR;
            rf_wr_sel_EXB  <= rf_wr_sel_IDR;
            alu_ctrl_EXB   <= alu_ctrl_IDR;
            alu_a_sel_EXB  <= alu_a_sel_IDR;
            alu_b_sel_EXB  <= alu_b_sel_IDR;
            dm_rd_ctrl_EXB <= dm_rd_ctrl_IDR;
            dm_wr_ctrl_EXB <= dm_wr_ctrl_IDR;
        end
    end

    // Counter 0 counts predictor updates, counter 1 counts redirects.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_bus;

    assign cnt_inc = {redirect_EXB, bp_upd_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating counter; clear beats a same-cycle increment.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (perf_clr) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign branch_cnt  = cnt_bus[0];
    assign mispred_cnt = cnt_bus[1];

endmodule

// File: tb/tb_pipeline_exb_stage_bp.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against a behavioural model of the stage (one 32-bit and one 4-bit counter DUT).
module tb_pipeline_exb_stage_bp;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rf_wr_en;
        logic [1:0]  rf_wr_sel;
        logic [3:0]  alu_ctrl;
        logic        alu_a_sel;
        logic        alu_b_sel;
        logic [2:0]  dm_rd;
        logic [2:0]  dm_wr;
    } regs_t;

    logic        clk = 1'b0;
    logic        reset, flush, stall, perf_clr;
    regs_t       in;
    logic        do_jump, is_jalr, is_branch, pred_taken;
    logic [2:0]  br_type;
    logic [63:0] pred_target;

    // DUT (CNT_W=32) outputs
    logic        redirect, upd_valid, upd_taken;
    logic [63:0] redirect_target, upd_pc, upd_target;
    logic        o_valid, o_rf_wr_en, o_alu_a_sel, o_alu_b_sel;
    logic [63:0] o_pc, o_rs1, o_rs2, o_imm;
    logic [4:0]  o_rd;
    logic [1:0]  o_rf_wr_sel;
    logic [3:0]  o_alu_ctrl;
    logic [2:0]  o_dm_rd, o_dm_wr;
    logic [31:0] branch_cnt, mispred_cnt;
    regs_t       q_obs;

    // DUT (CNT_W=4) outputs
    logic        d4_redirect, d4_upd_valid, d4_upd_taken;
    logic [63:0] d4_redirect_target, d4_upd_pc, d4_upd_target;
    logic        d4_valid, d4_rf_wr_en, d4_alu_a_sel, d4_alu_b_sel;
    logic [63:0] d4_pc, d4_rs1, d4_rs2, d4_imm;
    logic [4:0]  d4_rd;
    logic [1:0]  d4_rf_wr_sel;
    logic [3:0]  d4_alu_ctrl;
    logic [2:0]  d4_dm_rd, d4_dm_wr;
    logic [3:0]  d4_branch_cnt, d4_mispred_cnt;

    // Model state
    regs_t           e_q;
    longint unsigned e_br, e_mp, e_br4, e_mp4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign q_obs = {o_valid, o_pc, o_rs1, o_rs2, o_imm, o_rd, o_rf_wr_en, o_rf_wr_sel,
                    o_alu_ctrl, o_alu_a_sel, o_alu_b_sel, o_dm_rd, o_dm_wr};

    pipeline_exb_stage_bp #(.XLEN(64), .CNT_W(32), .ILEN_BYTES(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .perf_clr(perf_clr),
        .valid_IDR(in.valid), .pc_IDR(in.pc), .reg_data1_IDR(in.rs1), .reg_data2_IDR(in.rs2),
        .imm_IDR(in.imm), .rd_IDR(in.rd), .rf_wr_en_IDR(in.rf_wr_en), .rf_wr_sel_IDR(in.rf_wr_sel),
        .alu_ctrl_IDR(in.alu_ctrl), .alu_a_sel_IDR(in.alu_a_sel), .alu_b_sel_IDR(in.alu_b_sel),
        .dm_rd_ctrl_IDR(in.dm_rd), .dm_wr_ctrl_IDR(in.dm_wr), .do_jump_IDR(do_jump),
        .is_jalr_IDR(is_jalr), .is_branch_IDR(is_branch), .BrType_IDR(br_type),
        .pred_taken_IDR(pred_taken), .pred_target_IDR(pred_target),
        .redirect_EXB(redirect), .redirect_target_EXB(redirect_target),
        .bp_upd_valid(upd_valid), .bp_upd_pc(upd_pc), .bp_upd_taken(upd_taken),
        .bp_upd_target(upd_target), .valid_EXB(o_valid), .pc_EXB(o_pc),
        .reg_data1_EXB(o_rs1), .reg_data2_EXB(o_rs2), .imm_EXB(o_imm), .rd_EXB(o_rd),
        .rf_wr_en_EXB(o_rf_wr_en), .rf_wr_sel_EXB(o_rf_wr_sel), .alu_ctrl_EXB(o_alu_ctrl),
        .alu_a_sel_EXB(o_alu_a_sel), .alu_b_sel_EXB(o_alu_b_sel), .dm_rd_ctrl_EXB(o_dm_rd),
        .dm_wr_ctrl_EXB(o_dm_wr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    pipeline_exb_stage_bp #(.XLEN(64), .CNT_W(4), .ILEN_BYTES(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .perf_clr(perf_clr),
        .valid_IDR(in.valid), .pc_IDR(in.pc), .reg_data1_IDR(in.rs1), .reg_data2_IDR(in.rs2),
        .imm_IDR(in.imm), .rd_IDR(in.rd), .rf_wr_en_IDR(in.rf_wr_en), .rf_wr_sel_IDR(in.rf_wr_sel),
        .alu_ctrl_IDR(in.alu_ctrl), .alu_a_sel_IDR(in.alu_a_sel), .alu_b_sel_IDR(in.alu_b_sel),
        .dm_rd_ctrl_IDR(in.dm_rd), .dm_wr_ctrl_IDR(in.dm_wr), .do_jump_IDR(do_jump),
        .is_jalr_IDR(is_jalr), .is_branch_IDR(is_branch), .BrType_IDR(br_type),
        .pred_taken_IDR(pred_taken), .pred_target_IDR(pred_target),
        .redirect_EXB(d4_redirect), .redirect_target_EXB(d4_redirect_target),
        .bp_upd_valid(d4_upd_valid), .bp_upd_pc(d4_upd_pc), .bp_upd_taken(d4_upd_taken),
        .bp_upd_target(d4_upd_target), .valid_EXB(d4_valid), .pc_EXB(d4_pc),
        .reg_data1_EXB(d4_rs1), .reg_data2_EXB(d4_rs2), .imm_EXB(d4_imm), .rd_EXB(d4_rd),
        .rf_wr_en_EXB(d4_rf_wr_en), .rf_wr_sel_EXB(d4_rf_wr_sel), .alu_ctrl_EXB(d4_alu_ctrl),
        .alu_a_sel_EXB(d4_alu_a_sel), .alu_b_sel_EXB(d4_alu_b_sel), .dm_rd_ctrl_EXB(d4_dm_rd),
        .dm_wr_ctrl_EXB(d4_dm_wr), .branch_cnt(d4_branch_cnt), .mispred_cnt(d4_mispred_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for the combinational outputs.
    task automatic model_comb(output logic r, output logic [63:0] rt, output logic uv,
                              output logic [63:0] upc, output logic ut, output logic [63:0] utg);
        logic        c, tk, f, ctl, mp;
        logic [63:0] tg, np;
        case (br_type)
            3'd0:    c = (in.rs1 == in.rs2);
            3'd1:    c = (in.rs1 != in.rs2);
            3'd4:    c = ($signed(in.rs1) <  $signed(in.rs2));
            3'd5:    c = ($signed(in.rs1) >= $signed(in.rs2));
            3'd6:    c = (in.rs1 <  in.rs2);
            3'd7:    c = (in.rs1 >= in.rs2);
            default: c = 1'b0;
        endcase
        ctl = is_branch || do_jump || is_jalr;
        tk  = (is_branch && c) || do_jump || is_jalr;
        tg  = is_jalr ? ((in.rs1 + in.imm) & ~64'd1) : (in.pc + in.imm);
        np  = tk ? tg : (in.pc + 64'd4);
        mp  = (tk != pred_taken) || (tk && pred_taken && (pred_target != tg));
        f   = in.valid && !stall && !flush;
        r   = f && mp;
        rt  = r ? np : 64'd0;
        uv  = f && ctl;
        upc = uv ? in.pc : 64'd0;
        ut  = uv && tk;
        utg = uv ? tg : 64'd0;
    endtask

    function automatic longint unsigned cnt_next(longint unsigned c, logic inc, logic clr, int w);
        longint unsigned mx = (64'd1 << w) - 1;
        if (clr) return 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    task automatic check_regs();
        chk("valid_EXB", o_valid, e_q.valid);
        chk("pc_EXB", o_pc, e_q.pc);
        chk("reg_data1_EXB", o_rs1, e_q.rs1);
        chk("reg_data2_EXB", o_rs2, e_q.rs2);
        chk("imm_EXB", o_imm, e_q.imm);
        chk("rd_EXB", o_rd, e_q.rd);
        chk("rf_wr_en_EXB", o_rf_wr_en, e_q.rf_wr_en);
        chk("rf_wr_sel_EXB", o_rf_wr_sel, e_q.rf_wr_sel);
        chk("alu_ctrl_EXB", o_alu_ctrl, e_q.alu_ctrl);
        chk("alu_a_sel_EXB", o_alu_a_sel, e_q.alu_a_sel);
        chk("alu_b_sel_EXB", o_alu_b_sel, e_q.alu_b_sel);
        chk("dm_rd_ctrl_EXB", o_dm_rd, e_q.dm_rd);
        chk("dm_wr_ctrl_EXB", o_dm_wr, e_q.dm_wr);
        chk("d4_valid_EXB", d4_valid, e_q.valid);
        chk("d4_pc_EXB", d4_pc, e_q.pc);
        chk("branch_cnt", branch_cnt, e_br);
        chk("mispred_cnt", mispred_cnt, e_mp);
        chk("d4_branch_cnt", d4_branch_cnt, e_br4);
        chk("d4_mispred_cnt", d4_mispred_cnt, e_mp4);
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle();
        logic        r, uv, ut;
        logic [63:0] rt, upc, utg;
        #1;
        model_comb(r, rt, uv, upc, ut, utg);
        chk("redirect_EXB", redirect, r);
        chk("redirect_target_EXB", redirect_target, rt);
        chk("bp_upd_valid", upd_valid, uv);
        chk("bp_upd_pc", upd_pc, upc);
        chk("bp_upd_taken", upd_taken, ut);
        chk("bp_upd_target", upd_target, utg);
        chk("d4_redirect_EXB", d4_redirect, r);
        chk("d4_bp_upd_valid", d4_upd_valid, uv);
        if (flush)       e_q = '0;
        else if (!stall) e_q = in;
        e_br  = cnt_next(e_br,  uv, perf_clr, 32);
        e_mp  = cnt_next(e_mp,  r,  perf_clr, 32);
        e_br4 = cnt_next(e_br4, uv, perf_clr, 4);
        e_mp4 = cnt_next(e_mp4, r,  perf_clr, 4);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic clear_in();
        in = '0; do_jump = 0; is_jalr = 0; is_branch = 0; br_type = 0;
        pred_taken = 0; pred_target = 0; flush = 0; stall = 0; perf_clr = 0;
    endtask

    task automatic model_reset();
        e_q = '0; e_br = 0; e_mp = 0; e_br4 = 0; e_mp4 = 0;
    endtask

    task automatic set_branch(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, input logic [2:0] bt,
                              input logic pt, input logic [63:0] ptg);
        clear_in();
        in.valid = 1; in.pc = pc; in.rs1 = a; in.rs2 = b; in.imm = imm;
        is_branch = 1; br_type = bt; pred_taken = pt; pred_target = ptg;
    endtask

    initial begin
        logic [63:0] held_pc;
        longint unsigned mp_before;
        int kind;

        clear_in();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        reset = 1;

        // 1: BEQ taken, predicted not-taken -> redirect to 0x1020
        set_branch(64'h1000, 64'd5, 64'd5, 64'h20, 3'b000, 1'b0, 64'd0);
        #1;
        chk("t1_redirect", redirect, 1'b1);
        chk("t1_target", redirect_target, 64'h1020);
        chk("t1_upd_taken", upd_taken, 1'b1);
        cycle();
        chk("t1_mispred_cnt", mispred_cnt, 64'd1);
        chk("t1_valid_EXB", o_valid, 1'b1);
        chk("t1_pc_EXB", o_pc, 64'h1000);

        // 2: BLTU vs BLT on all-ones vs 1, both predicted correctly
        clear_in(); perf_clr = 1; cycle();
        set_branch(64'h1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 3'b110, 1'b0, 64'd0);
        #1;
        chk("t2_bltu_taken", upd_taken, 1'b0);
        chk("t2_bltu_redirect", redirect, 1'b0);
        cycle();
        set_branch(64'h1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 3'b100, 1'b1, 64'h1140);
        #1;
        chk("t2_blt_taken", upd_taken, 1'b1);
        chk("t2_blt_redirect", redirect, 1'b0);
        cycle();
        chk("t2_branch_cnt", branch_cnt, 64'd2);

        // 3: JALR target has bit0 cleared
        clear_in();
        in.valid = 1; in.pc = 64'h1200; in.rs1 = 64'h2003; in.imm = 64'h10;
        is_jalr = 1; pred_taken = 1; pred_target = 64'h2012;
        #1;
        chk("t3_target", upd_target, 64'h2012);
        chk("t3_redirect", redirect, 1'b0);
        cycle();
        pred_target = 64'h3000;
        #1;
        chk("t3b_redirect", redirect, 1'b1);
        chk("t3b_target", redirect_target, 64'h2012);
        cycle();

        // 4: mispredicting branch held by stall, one redirect on release
        held_pc = o_pc;
        mp_before = e_mp;
        set_branch(64'h1300, 64'd1, 64'd2, 64'h80, 3'b001, 1'b0, 64'd0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_redirect", redirect, 1'b0);
            cycle();
            chk("t4_held_pc", o_pc, held_pc);
        end
        stall = 0;
        #1;
        chk("t4_release_redirect", redirect, 1'b1);
        cycle();
        chk("t4_mispred_once", mispred_cnt, mp_before + 1);

        // 5: flush+stall kills the register; async reset mid-stall clears all
        clear_in();
        in.valid = 1; in.pc = 64'h1400; in.rf_wr_en = 1; in.dm_wr = 3'd3; in.rd = 5'd7;
        cycle();
        flush = 1; stall = 1;
        cycle();
        chk("t5_valid_EXB", o_valid, 1'b0);
        chk("t5_rf_wr_en_EXB", o_rf_wr_en, 1'b0);
        chk("t5_dm_wr_EXB", o_dm_wr, 3'd0);
        flush = 0; stall = 0;
        cycle();
        stall = 1;
        cycle();
        #2;
        reset = 0;
        #1;
        model_reset();
        check_regs();
        chk("t5_rst_redirect", redirect, 1'b0);
        chk("t5_rst_upd_valid", upd_valid, 1'b0);
        chk("t5_rst_rf_wr_en", o_rf_wr_en, 1'b0);
        @(negedge clk);
        reset = 1;
        clear_in();
        cycle();

        // 6: counter saturation on the 4-bit instance, then clear beats increment
        for (int i = 0; i < 16; i++) begin
            set_branch(64'h2000 + 64'(i * 4), 64'd1, 64'd2, 64'h8, 3'b000, 1'b0, 64'd0);
            cycle();
        end
        chk("t6_d4_saturated", d4_branch_cnt, 64'd15);
        chk("t6_branch_cnt", branch_cnt, 64'd16);
        perf_clr = 1;
        cycle();
        chk("t6_clr_d4", d4_branch_cnt, 64'd0);
        chk("t6_clr", branch_cnt, 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear_in();
            in.valid     = ($urandom_range(3) != 0);
            in.pc        = {$urandom, $urandom};
            in.rs1       = ($urandom_range(5) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
            in.rs2       = ($urandom_range(3) == 0) ? in.rs1 : {$urandom, $urandom};
            in.imm       = {$urandom, $urandom};
            in.rd        = 5'($urandom);
            in.rf_wr_en  = 1'($urandom);
            in.rf_wr_sel = 2'($urandom);
            in.alu_ctrl  = 4'($urandom);
            in.alu_a_sel = 1'($urandom);
            in.alu_b_sel = 1'($urandom);
            in.dm_rd     = 3'($urandom);
            in.dm_wr     = 3'($urandom);
            kind = int'($urandom_range(4));
            is_branch = (kind == 1) || (kind == 4);
            do_jump   = (kind == 2);
            is_jalr   = (kind == 3) || (kind == 4);
            br_type   = 3'($urandom);
            pred_taken = 1'($urandom);
            case ($urandom_range(2))
                0:       pred_target = in.pc + in.imm;
                1:       pred_target = (in.rs1 + in.imm) & ~64'd1;
                default: pred_target = {$urandom, $urandom};
            endcase
            flush    = ($urandom_range(7) == 0);
            stall    = ($urandom_range(3) == 0);
            perf_clr = ($urandom_range(15) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
